// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single synchronous-read memory.
// Data wins collisions unless fetch has been starved for STARVE_LIMIT cycles.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]            d_byte_en_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic                  mem_wr_en_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  stall_o
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_D    = 2'd2
  } resp_src_e;

  resp_src_e     resp_src_q, resp_src_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          we_q, we_d;
  logic          if_gnt, d_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_src_q   <= SRC_NONE;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
    end else begin
      resp_src_q   <= resp_src_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
    end
  end

  // Grants are forced low in reset so nothing reaches memory while rst=1.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req_i && d_req_i) begin
        if (starve_cnt_q >= LIMIT) if_gnt = 1'b1;
        else                       d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req_i;
        d_gnt  = d_req_i;
      end
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (if_req_i && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + CW'(1);
    end

    resp_src_d = SRC_NONE;
    if (d_gnt)       resp_src_d = SRC_D;
    else if (if_gnt) resp_src_d = SRC_IF;

    we_d = d_gnt ? d_we_i : we_q;
  end

  always_comb begin
    if_gnt_o      = if_gnt;
    d_gnt_o       = d_gnt;
    stall_o       = !rst && if_req_i && !if_gnt;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_wr_en_o   = 1'b0;
    mem_byte_en_o = '0;
    if (d_gnt) begin
      mem_addr_o    = d_addr_i;
      mem_wr_data_o = d_wdata_i;
      mem_wr_en_o   = d_we_i;
      mem_byte_en_o = d_we_i ? d_byte_en_i : 4'hF;
    end else if (if_gnt) begin
      mem_addr_o    = if_addr_i;
      mem_byte_en_o = 4'hF;
    end

    // Response phase is squashed during reset even if resp_src_q still holds a source.
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (!rst) begin
      if (resp_src_q == SRC_IF) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rd_data_i;
      end else if (resp_src_q == SRC_D) begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = we_q ? '0 : mem_rd_data_i;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width.
REQ-002 Parameter STARVE_LIMIT, default 4, the number of consecutive denied fetch-request cycles after which fetch is forced to win.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req_i  input  1  instruction-fetch request; if_addr_i is held stable until granted.
REQ-006 if_addr_i  input  DATA_WIDTH  fetch byte address.
REQ-007 if_gnt_o  output  1  fetch granted this cycle.
REQ-008 if_rvalid_o  output  1  fetch data valid; asserted one cycle after the fetch grant.
REQ-009 if_rdata_o  output  DATA_WIDTH  fetched instruction.
REQ-010 d_req_i  input  1  data-port request; d_we_i, d_addr_i, d_wdata_i and d_byte_en_i are held until granted.
REQ-011 d_we_i  input  1  1 = store, 0 = load.
REQ-012 d_addr_i, d_wdata_i  input  DATA_WIDTH each  data address and store data.
REQ-013 d_byte_en_i  input  4  store byte enables.
REQ-014 d_gnt_o  output  1  data access granted this cycle.
REQ-015 d_rvalid_o  output  1  data completion (load data or store ack), asserted one cycle after the data grant.
REQ-016 d_rdata_o  output  DATA_WIDTH  load data.
REQ-017 mem_addr_o, mem_wr_data_o  output  DATA_WIDTH each  shared memory address and write data.
REQ-018 mem_wr_en_o  output  1  memory write strobe.
REQ-019 mem_byte_en_o  output  4  memory byte enables.
REQ-020 mem_rd_data_i  input  DATA_WIDTH  memory read data, valid the cycle after the address is presented (synchronous read).
REQ-021 stall_o  output  1  asserted when if_req_i=1 and if_gnt_o=0; used to freeze the PC.

Function
REQ-022 Arbitration is combinational within a cycle: at most one of if_gnt_o or d_gnt_o is 1; a grant is only asserted when the matching request is 1.
REQ-023 Default priority: the data port wins when both ports request.
REQ-024 starve_cnt is a saturating counter: it increments when if_req_i=1 and if_gnt_o=0, and clears when if_gnt_o=1 or if_req_i=0.
REQ-025 When starve_cnt >= STARVE_LIMIT and both ports request, fetch wins.
REQ-026 Memory outputs follow the granted port: mem_addr_o, mem_wr_en_o (= d_we_i, data grant only), mem_wr_data_o and mem_byte_en_o; for a fetch or a load, mem_wr_en_o=0 and mem_byte_en_o=4'hF.
REQ-027 With no grant, all mem_*_o outputs are 0.
REQ-028 The response-phase register resp_src has three states, NONE/IF/D: it loads the granted source each cycle, and loads NONE when there is no grant.
REQ-029 When resp_src=IF: if_rvalid_o=1 and if_rdata_o=mem_rd_data_i.
REQ-030 When resp_src=D: d_rvalid_o=1; for a load, d_rdata_o=mem_rd_data_i; for a store, d_rdata_o=0. A registered copy of d_we_i distinguishes load from store.
REQ-031 Otherwise the rvalid outputs are 0 and the rdata outputs are 0.
REQ-032 Throughput: grants may occur on consecutive cycles (pipelined); the response phase of access N overlaps the address phase of access N+1.
REQ-033 Latency: a grant at cycle t produces rvalid at cycle t+1, exactly once per grant.
REQ-034 A request with no grant is retried implicitly while the request is held; no request is ever dropped.
REQ-035 stall_o is combinational and has no register.

Reset
REQ-036 While rst=1: resp_src=NONE, starve_cnt=0, and the registered we copy is 0.
REQ-037 While rst=1: all grants, rvalids, rdata and mem_*_o outputs are 0, and stall_o is 0.
REQ-038 Reset mid-operation: an outstanding response is discarded, and no rvalid is asserted in the cycle after rst deasserts.
REQ-039 The first grant is possible in the first cycle with rst=0.

Verification
REQ-040 Fetch only: if_req_i=1, if_addr_i=0x0000_0010, memory word 0x0050_0093 -> if_gnt_o=1 at t, if_rvalid_o=1 at t+1 with if_rdata_o=0x0050_0093, stall_o=0.
REQ-041 Collision: both ports request, with a load at d_addr_i=0x100 -> d_gnt_o=1, if_gnt_o=0, stall_o=1 at t; d_rvalid_o=1 at t+1 with data from 0x100.
REQ-042 Starvation: d_req_i held at 1 and if_req_i held at 1 for 6 cycles, STARVE_LIMIT=4 -> data granted on cycles 0-3, fetch granted on cycle 4, data on cycle 5.
REQ-043 Store: d_we_i=1, d_addr_i=0x200, d_wdata_i=0xDEAD_BEEF, d_byte_en_i=4'b0011 -> mem_wr_en_o=1 with the same address, data and enables at t; d_rvalid_o=1 and d_rdata_o=0 at t+1.
REQ-044 Back-to-back: fetches at 0x0, 0x4 and 0x8 on consecutive cycles -> if_rvalid_o=1 for 3 consecutive cycles with in-order data.
REQ-045 Reset mid-access: rst=1 in the cycle after a load grant -> d_rvalid_o=0 during reset and in the cycle following it; starve_cnt returns to 0.
